// File: rtl/sap1_loader_pkg.sv
// Shared types and constants for the SAP-1 program loader.
package sap1_loader_pkg;

    // Default stream/checksum word width.
    localparam int unsigned CHECKSUM_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Stream input and RAM write port of the program loader.
interface prog_loader_if #(
    parameter int unsigned RAM_DEPTH = 16,
    parameter int unsigned RAM_WIDTH = 8
);
    localparam int unsigned ADDRESS_WIDTH = $clog2(RAM_DEPTH);

    logic                     i_valid;
    logic [RAM_WIDTH-1:0]     i_data;
    logic                     o_ready;
    logic                     o_ram_we;
    logic [ADDRESS_WIDTH-1:0] o_ram_addr;
    logic [RAM_WIDTH-1:0]     o_ram_data;

    // Stream source / RAM sink side.
    modport master (
        output i_valid, i_data,
        input  o_ready, o_ram_we, o_ram_addr, o_ram_data
    );

    // Loader side.
    modport slave (
        input  i_valid, i_data,
        output o_ready, o_ram_we, o_ram_addr, o_ram_data
    );
endinterface

// File: rtl/loader_checksum.sv
// Clearable modular accumulator; zero_o tells whether sum + data_i wraps to zero.
module loader_checksum #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] sum_q, sum_d, sum_plus_c;

    // Lookahead sum lets the checksum word be judged on the cycle it arrives.
    assign sum_plus_c = sum_q + data_i;
    assign zero_o     = (sum_plus_c == '0);

    // Next sum: clear wins over add.
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_plus_c;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Program loader: freezes the CPU at an instruction boundary, streams words
// into RAM, verifies a trailing checksum and releases the CPU with a reset.
module prog_loader
    import sap1_loader_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = 16,
    parameter int unsigned RAM_WIDTH = CHECKSUM_WIDTH,
    localparam int unsigned ADDRESS_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 i_start,
    input  logic [ADDRESS_WIDTH:0] i_count,
    input  logic                 i_step_zero,
    prog_loader_if.slave         bus,
    output logic                 o_cpu_hold,
    output logic                 o_cpu_reset,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);
    localparam int unsigned CW = ADDRESS_WIDTH + 1;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
    logic [CW-1:0]            count_q, count_d;
    logic count_legal_c, ready_c, xfer_c, last_c;
    logic sum_clr_c, sum_add_c, sum_zero_c;
    logic we_c, hold_c, cpu_reset_c, done_c, error_c;

    assign count_legal_c = (i_count != '0) && (i_count <= CW'(RAM_DEPTH));
    assign ready_c       = clk_en && ((state_q == ST_LOAD) || (state_q == ST_CHECK));
    assign xfer_c        = bus.i_valid && ready_c;
    assign last_c        = ({1'b0, idx_q} == (count_q - CW'(1)));

    loader_checksum #(.WIDTH(RAM_WIDTH)) u_checksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sum_clr_c),
        .add_i  (sum_add_c),
        .data_i (bus.i_data),
        .zero_o (sum_zero_c)
    );

    // Next-state and output decode; every transition needs an enabled cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        sum_clr_c   = 1'b0;
        sum_add_c   = 1'b0;
        we_c        = 1'b0;
        hold_c      = 1'b0;
        cpu_reset_c = 1'b0;
        done_c      = 1'b0;
        error_c     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (state_q == ST_ERROR) begin
                    hold_c  = 1'b1;
                    error_c = 1'b1;
                end
                if (clk_en && i_start) begin
                    if (count_legal_c) begin
                        state_d   = ST_DRAIN;
                        count_d   = i_count;
                        idx_d     = '0;
                        sum_clr_c = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DRAIN: begin
                // Freeze only at an instruction boundary.
                if (clk_en && i_step_zero) begin
                    hold_c  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hold_c = 1'b1;
                if (xfer_c) begin
                    we_c      = 1'b1;
                    sum_add_c = 1'b1;
                    if (last_c) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + ADDRESS_WIDTH'(1);
                    end
                end
            end
            ST_CHECK: begin
                hold_c = 1'b1;
                if (xfer_c) begin
                    state_d = sum_zero_c ? ST_RELEASE : ST_ERROR;
                end
            end
            ST_RELEASE: begin
                hold_c = 1'b1;
                if (clk_en) begin
                    cpu_reset_c = 1'b1;
                    done_c      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, word index and latched count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign bus.o_ready    = ready_c;
    assign bus.o_ram_we   = we_c;
    assign bus.o_ram_addr = we_c ? idx_q : '0;
    assign bus.o_ram_data = we_c ? bus.i_data : '0;
    assign o_cpu_hold     = hold_c;
    assign o_cpu_reset    = cpu_reset_c;
    assign o_done         = done_c;
    assign o_error        = error_c;
    assign o_busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table of loads plus hand-written
// drain and mid-load reset sequences; RAM writes checked against a scoreboard.
module tb_prog_loader;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned NVEC  = 9;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        int unsigned count;
        logic [7:0]  base;
        logic [7:0]  step;
        logic [7:0]  delta;    // added to the correct checksum; nonzero corrupts it
        bit          en4;      // clk_en every 4th cycle
        bit          tgl;      // random i_valid
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    logic          clk, rst_n, clk_en, i_start, i_step_zero;
    logic [AW:0]   i_count;
    logic          o_cpu_hold, o_cpu_reset, o_busy, o_done, o_error;

    prog_loader_if #(.RAM_DEPTH(DEPTH), .RAM_WIDTH(WIDTH)) bus ();

    prog_loader #(.RAM_DEPTH(DEPTH), .RAM_WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .i_start     (i_start),
        .i_count     (i_count),
        .i_step_zero (i_step_zero),
        .bus         (bus.slave),
        .o_cpu_hold  (o_cpu_hold),
        .o_cpu_reset (o_cpu_reset),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_tot = 0;
    int          rst_tot  = 0;
    int          wr_tot   = 0;
    bit          en4 = 1'b0;
    int unsigned cyc;
    wr_t         sb[$];
    vec_t        vecs[NVEC];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock-enable pattern generator.
    initial begin
        clk_en = 1'b1;
        cyc    = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            clk_en = en4 ? (cyc % 4 == 0) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_cpu_hold, o_cpu_reset, o_busy, o_done, o_error,
                    bus.o_ready, bus.o_ram_we, bus.o_ram_addr, bus.o_ram_data});
    endfunction

    // Raise i_start until it is seen on an enabled cycle.
    task automatic do_start(input int unsigned cnt);
        int g   = 0;
        bit acc = 1'b0;
        @(posedge clk);
        #2;
        i_start = 1'b1;
        i_count = (AW+1)'(cnt);
        while (!acc && g < 100) begin
            @(negedge clk);
            if (clk_en) begin
                acc = 1'b1;
            end else begin
                @(posedge clk);
                #2;
            end
            g++;
        end
        if (!acc) check("start_timeout", 32'(acc), 1);
        @(posedge clk);
        #2;
        i_start = 1'b0;
    endtask

    // Offer one word until a handshake cycle; the transfer lands on the next edge.
    task automatic send_word(input logic [7:0] d, input bit tgl);
        int g   = 0;
        bit acc = 1'b0;
        while (!acc && g < 400) begin
            @(posedge clk);
            #2;
            bus.i_valid = tgl ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_data  = d;
            @(negedge clk);
            if (bus.i_valid && bus.o_ready) acc = 1'b1;
            g++;
        end
        if (!acc) check("send_timeout", 32'(acc), 1);
    endtask

    task automatic settle();
        int g = 0;
        @(negedge clk);
        while (o_busy && !o_error && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) check("settle_timeout", 32'(o_busy), 0);
        #1;
    endtask

    task automatic run_load(input vec_t v, input int id);
        int         d0, r0, w0;
        logic [7:0] sum, d, chk;
        wr_t        e;
        bit         legal;
        legal = (v.count >= 1) && (v.count <= DEPTH);
        en4   = v.en4;
        d0 = done_tot; r0 = rst_tot; w0 = wr_tot;
        do_start(v.count);
        if (legal) begin
            @(negedge clk);
            check($sformatf("v%0d_start_clears_err", id), 32'(o_error), 0);
            sum = 8'h00;
            d   = v.base;
            for (int i = 0; i < int'(v.count); i++) begin
                e.addr = AW'(i);
                e.data = d;
                sb.push_back(e);
                send_word(d, v.tgl);
                sum = sum + d;
                d   = d + v.step;
            end
            chk = -sum;
            chk = chk + v.delta;
            send_word(chk, v.tgl);
            @(posedge clk);
            #2;
            bus.i_valid = 1'b0;
        end
        settle();
        check($sformatf("v%0d_done_pulses", id), 32'(done_tot - d0), 32'(v.exp_done));
        check($sformatf("v%0d_cpu_reset_pulses", id), 32'(rst_tot - r0), 32'(v.exp_done));
        check($sformatf("v%0d_error", id), 32'(o_error), 32'(v.exp_err));
        check($sformatf("v%0d_cpu_hold", id), 32'(o_cpu_hold), 32'(v.exp_err));
        check($sformatf("v%0d_busy", id), 32'(o_busy), 32'(v.exp_err));
        check($sformatf("v%0d_writes", id), 32'(wr_tot - w0), legal ? 32'(v.count) : 32'd0);
        check($sformatf("v%0d_sb_left", id), 32'(sb.size()), 0);
        sb.delete();
    endtask

    initial begin
        vec_t       one;
        wr_t        e;
        int         d0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_count     = '0;
        i_step_zero = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        vecs[0] = '{3,  8'h11, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{3,  8'h11, 8'h11, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1,  8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{0,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{5,  8'h80, 8'h40, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{17, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16, 8'h03, 8'h07, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{2,  8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{4,  8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        // Write / pulse monitor, sampled on the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (o_done) done_tot++;
                if (o_cpu_reset) rst_tot++;
                if (bus.o_ram_we) begin
                    wr_tot++;
                    check("write_expected", 32'(sb.size() != 0), 1);
                    check("write_on_enabled_cycle", 32'(clk_en), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("wr_addr", 32'(bus.o_ram_addr), 32'(e.addr));
                        check("wr_data", 32'(bus.o_ram_data), 32'(e.data));
                    end
                end
            end
        join_none

        #23;
        check("reset_outs", all_outs(), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        for (int i = 0; i < int'(NVEC); i++) begin
            run_load(vecs[i], i);
        end

        // Drain: CPU keeps running until it reaches step 0.
        en4 = 1'b0;
        i_step_zero = 1'b0;
        d0 = done_tot;
        do_start(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("drain%0d_hold", i), 32'(o_cpu_hold), 0);
            check($sformatf("drain%0d_ready", i), 32'(bus.o_ready), 0);
            check($sformatf("drain%0d_busy", i), 32'(o_busy), 1);
        end
        @(posedge clk);
        #2;
        i_step_zero = 1'b1;
        @(negedge clk);
        check("drain_hold_at_step0", 32'(o_cpu_hold), 1);
        e.addr = '0;
        e.data = 8'h42;
        sb.push_back(e);
        @(posedge clk);
        #2;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h42;
        @(negedge clk);
        check("load_entered", 32'(bus.o_ready), 1);
        send_word(8'hBE, 1'b0);
        @(posedge clk);
        #2;
        bus.i_valid = 1'b0;
        settle();
        check("drain_done", 32'(done_tot - d0), 1);
        check("drain_error", 32'(o_error), 0);
        check("drain_sb_left", 32'(sb.size()), 0);
        sb.delete();

        // Reset in the middle of a 4-word load.
        do_start(4);
        for (int i = 0; i < 2; i++) begin
            e.addr = AW'(i);
            e.data = 8'(8'h30 + i);
            sb.push_back(e);
            send_word(e.data, 1'b0);
        end
        @(posedge clk);
        #2;
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 0);
        check("reset_sb_left", 32'(sb.size()), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        one = '{1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        run_load(one, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter RAM_DEPTH, default 16: number of RAM words; ADDRESS_WIDTH = clog2(RAM_DEPTH), derived, not overridable.
REQ-002 Parameter RAM_WIDTH, default 8: RAM word width; also the stream data and checksum width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clk_en  input  1  system clock enable; the FSM advances only on cycles with clk_en=1.
REQ-006 i_start  input  1  load request, sampled in IDLE.
REQ-007 i_count  input  ADDRESS_WIDTH+1  words to load, sampled with i_start; legal range 1..RAM_DEPTH.
REQ-008 i_step_zero  input  1  CPU instruction counter is at step 0 (instruction boundary).
REQ-009 i_valid  input  1  stream word valid.
REQ-010 i_data  input  RAM_WIDTH  stream word.
REQ-011 o_ready  output  1  loader accepts the stream word this cycle.
REQ-012 o_cpu_hold  output  1  CPU clk_en gate; while high the CPU datapath shall not advance.
REQ-013 o_cpu_reset  output  1  one-enabled-cycle pulse clearing PC and instruction counter.
REQ-014 o_ram_we, o_ram_addr[ADDRESS_WIDTH], o_ram_data[RAM_WIDTH]  output  RAM write port, overriding bus-driven writes while o_cpu_hold=1.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_done  output  1  one-enabled-cycle pulse on successful load.
REQ-017 o_error  output  1  sticky checksum-fail flag; cleared by the next accepted i_start or by reset.

Function
REQ-018 States: IDLE, DRAIN, LOAD, CHECK, RELEASE, ERROR.
REQ-019 IDLE: i_start=1 with legal i_count -> DRAIN; latch count, clear address, sum and o_error; illegal i_count (0 or >RAM_DEPTH) -> ERROR.
REQ-020 DRAIN: o_cpu_hold=1 once i_step_zero=1, then LOAD on the same enabled cycle; remains in DRAIN while i_step_zero=0.
REQ-021 LOAD: o_ready = clk_en; transfer = i_valid & o_ready; each transfer asserts o_ram_we the same cycle, o_ram_addr = word index, o_ram_data = i_data; index then increments.
REQ-022 Transfer of word number count-1 (last) -> CHECK; index never wraps, because count <= RAM_DEPTH.
REQ-023 i_valid=0 in LOAD: stall with no write and no timeout.
REQ-024 CHECK: o_ready = clk_en; one transfer consumes the checksum word, which is not written; (sum of data words + checksum) mod 2^RAM_WIDTH == 0 -> RELEASE, otherwise -> ERROR.
REQ-025 RELEASE: o_cpu_reset=1 and o_done=1 for one enabled cycle, then IDLE; o_cpu_hold drops on entry to IDLE.
REQ-026 ERROR: o_error=1, o_cpu_hold stays 1 (CPU frozen), o_ram_we=0; i_start=1 -> DRAIN with a restart identical to IDLE.
REQ-027 i_start outside IDLE/ERROR is ignored.
REQ-028 clk_en=0: no state, index or sum change; o_ready=0, o_ram_we=0.
REQ-029 o_ram_we only in LOAD; o_cpu_hold is 1 in LOAD, CHECK, RELEASE and ERROR.

Reset
REQ-030 rst_n=0 immediately forces IDLE, index=0, sum=0, and all outputs 0 (o_ready, o_cpu_hold, o_cpu_reset, o_ram_we, o_done, o_error, o_busy, o_ram_addr, o_ram_data).
REQ-031 Reset mid-LOAD abandons the load; RAM words already written are not restored.

Structure
REQ-032 Package sap1_loader_pkg holds the state enumeration and the checksum-width constant.
REQ-033 One sub-module, loader_checksum: clearable modular accumulator with add-enable and zero-check output.

Verification
REQ-034 count=3, data 0x11,0x22,0x33, checksum 0x9A, i_step_zero=1 -> RAM[0..2]=0x11,0x22,0x33; o_done pulses once; o_error=0.
REQ-035 Same stream with checksum 0x00 -> ERROR: o_error=1, o_cpu_hold=1, RAM[0..2] written, no o_cpu_reset.
REQ-036 i_start while i_step_zero=0 for 5 enabled cycles -> o_cpu_hold=0 and o_ready=0 for those 5 cycles; LOAD entered on the first cycle i_step_zero=1.
REQ-037 count=16 with clk_en asserted every 4th cycle and i_valid toggling -> exactly 16 writes, addresses 0..15, no wrap, each write on an enabled cycle.
REQ-038 rst_n pulsed low after the 2nd word of count=4 -> all outputs 0 asynchronously; a subsequent count=1 load succeeds at address 0.
REQ-039 i_count=0 or 17 -> ERROR without any RAM write; a next legal i_start clears o_error.
